// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the byte-wide RAM port controller.
//   - access width codes carried on mem_width
//   - FSM state encoding
//   - width_last:  width code -> index of the last byte lane (N-1)
//   - extend_load: sign/zero extension of assembled load data
package mem_ctrl_pkg;

  localparam logic [1:0] MemWByte = 2'd0;
  localparam logic [1:0] MemWHalf = 2'd1;
  localparam logic [1:0] MemWWord = 2'd2;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StRd     = 3'd1,
    StWr     = 3'd2,
    StRdTail = 3'd3,
    StDone   = 3'd4
  } state_e;

  // Code 2'd3 is treated as a word access.
  function automatic logic [1:0] width_last(input logic [1:0] width);
    case (width)
      MemWByte: return 2'd0;
      MemWHalf: return 2'd1;
      default:  return 2'd3;
    endcase
  endfunction

  function automatic logic [31:0] extend_load(input logic [31:0] raw, input logic [1:0] last,
                                              input logic sgn);
    case (last)
      2'd0:    return {{24{raw[7] & sgn}}, raw[7:0]};
      2'd1:    return {{16{raw[15] & sgn}}, raw[15:0]};
      default: return raw;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates and sequences a single byte-wide synchronous RAM port between
// instruction fetch (IF) and the MEM stage. Each access is split into 1/2/4
// little-endian byte cycles; load bytes are assembled and extended.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   if_req/if_addr            fetch request (always word, unsigned), held until if_done
//   if_done/if_inst           one-cycle completion pulse, fetched word (held between pulses)
//   mem_req/we/width/signed   MEM-stage request and access attributes, held until mem_done
//   mem_addr/mem_wdata        byte address, store data (low 1/2/4 bytes used)
//   mem_done/mem_rdata        one-cycle completion pulse, extended load data (held)
//   ram_a/ram_wr/ram_dout     RAM byte address, write strobe, write byte
//   ram_din                   RAM read byte, valid one cycle after ram_a
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_done,
  output logic [31:0]       if_inst,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_width,
  input  logic              mem_signed,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din
);

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  last_q, last_d;      // N-1
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        signed_q, signed_d;
  logic        owner_q, owner_d;    // 1 = MEM stage, 0 = IF
  logic [31:0] lanes_q, lanes_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;

  logic [1:0]  lane_idx;
  logic [31:0] rd_word;
  logic [31:0] addr_sum;
  logic        busy;

  // Byte requested in the previous cycle arrives now on ram_din.
  assign lane_idx = cnt_q - 2'd1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    signed_d    = signed_q;
    owner_d     = owner_q;
    lanes_d     = lanes_q;
    if_inst_d   = if_inst_q;
    mem_rdata_d = mem_rdata_q;
    rd_word     = lanes_q;

    case (state_q)
      StIdle: begin
        // Fixed priority: the MEM stage wins over fetch.
        if (mem_req) begin
          owner_d  = 1'b1;
          addr_d   = mem_addr;
          wdata_d  = mem_wdata;
          signed_d = mem_signed;
          last_d   = width_last(mem_width);
          cnt_d    = 2'd0;
          state_d  = mem_we ? StWr : StRd;
        end else if (if_req) begin
          owner_d  = 1'b0;
          addr_d   = if_addr;
          wdata_d  = 32'h0;
          signed_d = 1'b0;
          last_d   = 2'd3;
          cnt_d    = 2'd0;
          state_d  = StRd;
        end
      end

      StRd: begin
        if (cnt_q != 2'd0) begin
          lanes_d[{lane_idx, 3'b000} +: 8] = ram_din;
        end
        if (cnt_q == last_q) begin
          state_d = StRdTail;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end

      StWr: begin
        if (cnt_q == last_q) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end

      StRdTail: begin
        // Merge the final byte straight into the output register.
        rd_word[{last_q, 3'b000} +: 8] = ram_din;
        lanes_d = rd_word;
        if (owner_q) begin
          mem_rdata_d = extend_load(rd_word, last_q, signed_q);
        end else begin
          if_inst_d = rd_word;
        end
        state_d = StDone;
      end

      // Requests are not sampled here, so a still-held req is not re-accepted.
      StDone: state_d = StIdle;

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 2'd0;
      last_q      <= 2'd0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      signed_q    <= 1'b0;
      owner_q     <= 1'b0;
      lanes_q     <= 32'h0;
      if_inst_q   <= 32'h0;
      mem_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      signed_q    <= signed_d;
      owner_q     <= owner_d;
      lanes_q     <= lanes_d;
      if_inst_q   <= if_inst_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  // Full 32-bit add; truncation to ADDR_W makes the address wrap.
  assign addr_sum = addr_q + {30'd0, cnt_q};
  assign busy     = (state_q == StRd) || (state_q == StWr);

  assign ram_a     = busy ? addr_sum[ADDR_W-1:0] : '0;
  assign ram_wr    = (state_q == StWr);
  assign ram_dout  = ram_wr ? wdata_q[{cnt_q, 3'b000} +: 8] : 8'h00;
  assign if_done   = (state_q == StDone) && !owner_q;
  assign mem_done  = (state_q == StDone) && owner_q;
  assign if_inst   = if_inst_q;
  assign mem_rdata = mem_rdata_q;

  if (ADDR_W < 32) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr_sum[31:ADDR_W];
  end

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  localparam int unsigned AW = 17;

  logic          clk;
  logic          rst;
  logic          if_req;
  logic [31:0]   if_addr;
  logic          if_done;
  logic [31:0]   if_inst;
  logic          mem_req;
  logic          mem_we;
  logic [1:0]    mem_width;
  logic          mem_signed;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_done;
  logic [31:0]   mem_rdata;
  logic [AW-1:0] ram_a;
  logic          ram_wr;
  logic [7:0]    ram_dout;
  logic [7:0]    ram_din;

  mem_ctrl #(.ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_done   (if_done),
    .if_inst   (if_inst),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_width (mem_width),
    .mem_signed(mem_signed),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_done  (mem_done),
    .mem_rdata (mem_rdata),
    .ram_a     (ram_a),
    .ram_wr    (ram_wr),
    .ram_dout  (ram_dout),
    .ram_din   (ram_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read RAM model with a bench-side preload port.
  logic [7:0]    ram [0:(1<<AW)-1];
  logic          pl_en;
  logic [AW-1:0] pl_a;
  logic [7:0]    pl_d;

  always @(posedge clk) begin
    if (pl_en) ram[pl_a] <= pl_d;
    else if (ram_wr) ram[ram_a] <= ram_dout;
    ram_din <= ram[ram_a];
  end

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    logic        chk;
    logic [31:0] val;
  } exp_t;

  exp_t q_if[$];
  exp_t q_mem[$];

  // Monitor: every done pulse pops the expected response for that requester.
  always @(negedge clk) begin
    exp_t e;
    if (if_done) begin
      if (q_if.size() == 0) check("if_done unexpected", 32'd1, 32'd0);
      else begin
        e = q_if.pop_front();
        check("if_inst", if_inst, e.val);
      end
    end
    if (mem_done) begin
      if (q_mem.size() == 0) check("mem_done unexpected", 32'd1, 32'd0);
      else begin
        e = q_mem.pop_front();
        if (e.chk) check("mem_rdata", mem_rdata, e.val);
      end
    end
  end

  logic [AW-1:0] tr_a  [1:10];
  logic          tr_wr [1:10];
  logic [7:0]    tr_d  [1:10];

  task automatic preload(input logic [AW-1:0] a, input logic [7:0] d);
    pl_a  = a;
    pl_d  = d;
    pl_en = 1'b1;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  // Issues one request from an idle controller; k_done is the cycle (T0+k) of the done pulse.
  task automatic access(input bit is_if, input logic we, input logic [1:0] width, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic chk,
                        input logic [31:0] exp, output int k_done);
    exp_t e;
    e.chk = chk;
    e.val = exp;
    @(posedge clk);
    #1;
    if (is_if) begin
      q_if.push_back(e);
      if_req  = 1'b1;
      if_addr = addr;
    end else begin
      q_mem.push_back(e);
      mem_req    = 1'b1;
      mem_we     = we;
      mem_width  = width;
      mem_signed = sgn;
      mem_addr   = addr;
      mem_wdata  = wdata;
    end
    @(posedge clk);  // T0
    k_done = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k <= 10) begin
        tr_a[k]  = ram_a;
        tr_wr[k] = ram_wr;
        tr_d[k]  = ram_dout;
      end
      if ((is_if && if_done) || (!is_if && mem_done)) begin
        k_done = k;
        break;
      end
    end
    if (is_if) if_req = 1'b0;
    else mem_req = 1'b0;
    if (k_done == 0) check("done timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    int k_if;
    int k_mem;
    rst = 1'b1;
    if_req = 1'b0; if_addr = 32'h0;
    mem_req = 1'b0; mem_we = 1'b0; mem_width = MemWByte; mem_signed = 1'b0;
    mem_addr = 32'h0; mem_wdata = 32'h0;
    pl_en = 1'b0; pl_a = '0; pl_d = 8'h0;

    preload(17'h00100, 8'h13);
    preload(17'h00101, 8'h05);
    preload(17'h00102, 8'h00);
    preload(17'h00103, 8'h00);
    preload(17'h00020, 8'h80);
    preload(17'h1FFFF, 8'h34);
    preload(17'h00000, 8'h92);

    @(negedge clk);
    check("reset ram_a", 32'(ram_a), 32'h0);
    check("reset ram_wr", 32'(ram_wr), 32'h0);
    check("reset ram_dout", 32'(ram_dout), 32'h0);
    check("reset if_done", 32'(if_done), 32'h0);
    check("reset mem_done", 32'(mem_done), 32'h0);
    check("reset if_inst", if_inst, 32'h0);
    check("reset mem_rdata", mem_rdata, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Instruction fetch, word at 0x100.
    access(1'b1, 1'b0, MemWWord, 1'b0, 32'h100, 32'h0, 1'b1, 32'h0000_0513, k);
    check("fetch latency", 32'(k), 32'd6);
    for (int i = 1; i <= 4; i++) begin
      check("fetch ram_a", 32'(tr_a[i]), 32'h100 + 32'(i - 1));
      check("fetch ram_wr", 32'(tr_wr[i]), 32'h0);
    end
    check("fetch tail ram_a", 32'(tr_a[5]), 32'h0);

    // Byte loads, signed and unsigned.
    access(1'b0, 1'b0, MemWByte, 1'b1, 32'h20, 32'h0, 1'b1, 32'hFFFF_FF80, k);
    check("lb latency", 32'(k), 32'd3);
    access(1'b0, 1'b0, MemWByte, 1'b0, 32'h20, 32'h0, 1'b1, 32'h0000_0080, k);
    check("lbu latency", 32'(k), 32'd3);

    // Word store.
    access(1'b0, 1'b1, MemWWord, 1'b0, 32'h40, 32'hDEAD_BEEF, 1'b0, 32'h0, k);
    check("sw latency", 32'(k), 32'd5);
    for (int i = 1; i <= 4; i++) begin
      check("sw ram_wr", 32'(tr_wr[i]), 32'h1);
      check("sw ram_a", 32'(tr_a[i]), 32'h40 + 32'(i - 1));
    end
    check("sw byte0", 32'(tr_d[1]), 32'hEF);
    check("sw byte1", 32'(tr_d[2]), 32'hBE);
    check("sw byte2", 32'(tr_d[3]), 32'hAD);
    check("sw byte3", 32'(tr_d[4]), 32'hDE);
    check("sw done ram_wr", 32'(tr_wr[5]), 32'h0);
    check("mem_rdata held over store", mem_rdata, 32'h0000_0080);

    access(1'b0, 1'b0, MemWWord, 1'b0, 32'h40, 32'h0, 1'b1, 32'hDEAD_BEEF, k);
    check("lw latency", 32'(k), 32'd6);

    // Byte store uses only the low byte of wdata.
    access(1'b0, 1'b1, MemWByte, 1'b0, 32'h41, 32'h1234_565A, 1'b0, 32'h0, k);
    check("sb latency", 32'(k), 32'd2);
    check("sb ram_a", 32'(tr_a[1]), 32'h41);
    check("sb byte", 32'(tr_d[1]), 32'h5A);
    access(1'b0, 1'b0, 2'd3, 1'b1, 32'h40, 32'h0, 1'b1, 32'hDEAD_5AEF, k);
    check("width3 latency", 32'(k), 32'd6);
    access(1'b0, 1'b0, MemWHalf, 1'b0, 32'h42, 32'h0, 1'b1, 32'h0000_DEAD, k);
    check("lhu latency", 32'(k), 32'd4);

    // Signed half across the address wrap.
    access(1'b0, 1'b0, MemWHalf, 1'b1, 32'h1FFFF, 32'h0, 1'b1, 32'hFFFF_9234, k);
    check("wrap latency", 32'(k), 32'd4);
    check("wrap ram_a0", 32'(tr_a[1]), 32'h1FFFF);
    check("wrap ram_a1", 32'(tr_a[2]), 32'h0);

    // Simultaneous requests: MEM first, IF accepted one cycle after mem_done.
    @(posedge clk);
    #1;
    q_mem.push_back('{chk: 1'b1, val: 32'hFFFF_FF80});
    q_if.push_back('{chk: 1'b1, val: 32'h0000_0513});
    if_req = 1'b1; if_addr = 32'h100;
    mem_req = 1'b1; mem_we = 1'b0; mem_width = MemWByte; mem_signed = 1'b1; mem_addr = 32'h20;
    @(posedge clk);  // T0
    k_if = 0;
    k_mem = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (mem_done && k_mem == 0) begin
        k_mem = i;
        mem_req = 1'b0;
      end
      if (if_done && k_if == 0) begin
        k_if = i;
        if_req = 1'b0;
        break;
      end
    end
    if_req = 1'b0;
    mem_req = 1'b0;
    check("arb mem latency", 32'(k_mem), 32'd3);
    check("arb if latency", 32'(k_if), 32'd10);

    // Reset in the middle of a word fetch drops it.
    @(posedge clk);
    #1 if_req = 1'b1; if_addr = 32'h100;
    @(posedge clk);  // T0
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    if_req = 1'b0;
    @(negedge clk);
    check("rst ram_a", 32'(ram_a), 32'h0);
    check("rst ram_wr", 32'(ram_wr), 32'h0);
    check("rst if_done", 32'(if_done), 32'h0);
    check("rst if_inst", if_inst, 32'h0);
    check("rst mem_rdata", mem_rdata, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    access(1'b1, 1'b0, MemWWord, 1'b0, 32'h100, 32'h0, 1'b1, 32'h0000_0513, k);
    check("reissue latency", 32'(k), 32'd6);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("if queue drained", 32'(q_if.size()), 32'd0);
    check("mem queue drained", 32'(q_mem.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
